// File: rtl/fp32_stream_accum.sv
// Reduces a valid/ready stream of FP32 operands into one FP32 sum per packet.
// This block does no FP arithmetic. It launches operand pairs into an external adder
// through registers, waits a fixed latency, and captures the result back into the
// accumulator.
module fp32_stream_accum #(
  parameter int unsigned ADD_LAT = 0,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [31:0]      i_in_data,
  input  logic             i_in_last,
  output logic [31:0]      o_add_a,
  output logic [31:0]      o_add_b,
  input  logic [31:0]      i_add_o,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [31:0]      o_out_data,
  output logic [CNT_W-1:0] o_out_count,
  output logic             o_busy
);

  localparam int unsigned WcntW = (ADD_LAT > 0) ? $clog2(ADD_LAT + 1) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StAcc,
    StWait,
    StDone
  } state_e;

  state_e             r_state;
  logic [31:0]        r_acc;
  logic [31:0]        r_add_a;
  logic [31:0]        r_add_b;
  logic [31:0]        r_out_data;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   r_out_count;
  logic               r_last;
  logic               r_out_valid;
  logic [WcntW-1:0]   r_wcnt;

  logic               w_in_ready;
  logic               w_in_fire;
  logic               w_out_fire;
  logic [CNT_W-1:0]   w_cnt_inc;

  // Input readiness depends on state alone, so it never combinationally follows in_valid.
  assign w_in_ready = (r_state == StIdle) || (r_state == StAcc);
  assign w_in_fire  = i_in_valid && w_in_ready;
  assign w_out_fire = r_out_valid && i_out_ready;

  // Element count sticks at all-ones instead of wrapping.
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);

  // Sequencer: accept, launch, wait for the adder, then present the packet result.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_acc       <= '0;
      r_add_a     <= '0;
      r_add_b     <= '0;
      r_out_data  <= '0;
      r_cnt       <= '0;
      r_out_count <= '0;
      r_last      <= 1'b0;
      r_out_valid <= 1'b0;
      r_wcnt      <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_in_fire) begin
            // First element seeds the accumulator directly; the adder is not involved.
            r_acc <= i_in_data;
            r_cnt <= CNT_W'(1);
            if (i_in_last) begin
              r_out_data  <= i_in_data;
              r_out_count <= CNT_W'(1);
              r_out_valid <= 1'b1;
              r_state     <= StDone;
            end else begin
              r_state <= StAcc;
            end
          end
        end
        StAcc: begin
          if (w_in_fire) begin
            r_add_a <= r_acc;
            r_add_b <= i_in_data;
            r_last  <= i_in_last;
            r_cnt   <= w_cnt_inc;
            r_wcnt  <= WcntW'(ADD_LAT);
            r_state <= StWait;
          end
        end
        StWait: begin
          if (r_wcnt == '0) begin
            r_acc <= i_add_o;
            if (r_last) begin
              r_out_data  <= i_add_o;
              r_out_count <= r_cnt;
              r_out_valid <= 1'b1;
              r_state     <= StDone;
            end else begin
              r_state <= StAcc;
            end
          end else begin
            r_wcnt <= r_wcnt - WcntW'(1);
          end
        end
        StDone: begin
          if (w_out_fire) begin
            r_out_valid <= 1'b0;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_in_ready  = w_in_ready;
  assign o_add_a     = r_add_a;
  assign o_add_b     = r_add_b;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_out_count = r_out_count;
  assign o_busy      = (r_state != StIdle);

endmodule

// File: tb/tb_fp32_stream_accum.sv
// Bench for fp32_stream_accum. It drives three instances: ADD_LAT=0, ADD_LAT=2 with a
// two-stage adder, and ADD_LAT=0 with a 2-bit counter. Expected sums come from real
// arithmetic on small half-integer operands, whose sums are exact in FP32.
module tb_fp32_stream_accum;

  logic        clk;
  logic        rst_n;
  logic        in_valid  [3];
  logic        in_ready  [3];
  logic [31:0] in_data   [3];
  logic        in_last   [3];
  logic [31:0] add_a     [3];
  logic [31:0] add_b     [3];
  logic        out_valid [3];
  logic        out_ready [3];
  logic [31:0] out_data  [3];
  logic [15:0] out_count [3];
  logic        busy      [3];
  logic [15:0] cnt0;
  logic [15:0] cnt1;
  logic [1:0]  cnt2;
  logic [31:0] ao0;
  logic [31:0] ao1;
  logic [31:0] ao2;
  logic [31:0] p1;
  logic [31:0] p2;

  int lat [3] = '{0, 2, 0};
  int cw  [3] = '{16, 16, 2};
  int checks   = 0;
  int failures = 0;

  // FP32 <-> real conversions, valid only for zero and normal values.
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    logic [10:0] e;
    if (f[30:0] == 31'h0) return 0.0;
    e = {3'b000, f[30:23]} + 11'd896;
    d = {f[31], e, f[22:0], 29'h0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] b;
    logic [10:0] e;
    if (r == 0.0) return 32'h0;
    b = $realtobits(r);
    e = b[62:52] - 11'd896;
    return {b[63], e[7:0], b[51:29]};
  endfunction

  // Adder models: combinational for instances 0 and 2, two registered stages for instance 1.
  always_comb ao0 = r2f(f2r(add_a[0]) + f2r(add_b[0]));
  always_comb ao2 = r2f(f2r(add_a[2]) + f2r(add_b[2]));
  always @(posedge clk) begin
    p1 <= r2f(f2r(add_a[1]) + f2r(add_b[1]));
    p2 <= p1;
  end
  assign ao1 = p2;

  assign out_count[0] = cnt0;
  assign out_count[1] = cnt1;
  assign out_count[2] = {14'h0, cnt2};

  fp32_stream_accum #(.ADD_LAT(0), .CNT_W(16)) u_l0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid[0]), .o_in_ready(in_ready[0]),
    .i_in_data(in_data[0]), .i_in_last(in_last[0]), .o_add_a(add_a[0]), .o_add_b(add_b[0]),
    .i_add_o(ao0), .o_out_valid(out_valid[0]), .i_out_ready(out_ready[0]),
    .o_out_data(out_data[0]), .o_out_count(cnt0), .o_busy(busy[0])
  );

  fp32_stream_accum #(.ADD_LAT(2), .CNT_W(16)) u_l2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid[1]), .o_in_ready(in_ready[1]),
    .i_in_data(in_data[1]), .i_in_last(in_last[1]), .o_add_a(add_a[1]), .o_add_b(add_b[1]),
    .i_add_o(ao1), .o_out_valid(out_valid[1]), .i_out_ready(out_ready[1]),
    .o_out_data(out_data[1]), .o_out_count(cnt1), .o_busy(busy[1])
  );

  fp32_stream_accum #(.ADD_LAT(0), .CNT_W(2)) u_c2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid[2]), .o_in_ready(in_ready[2]),
    .i_in_data(in_data[2]), .i_in_last(in_last[2]), .o_add_a(add_a[2]), .o_add_b(add_b[2]),
    .i_add_o(ao2), .o_out_valid(out_valid[2]), .i_out_ready(out_ready[2]),
    .o_out_data(out_data[2]), .o_out_count(cnt2), .o_busy(busy[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_val();
    int k;
    k = int'($urandom_range(128)) - 64;
    if (k == 0) k = 1;
    return r2f(real'(k) * 0.5);
  endfunction

  // Drives one packet into instance k and checks handshake timing and the result.
  task automatic run_pkt(input int k, input logic [31:0] vals[$], input int gap_max,
                         input int bp_max, input string tag);
    int          n;
    int          sat;
    int          exp_c;
    int          w;
    int          exp_w;
    int          gap;
    int          bp;
    real         s;
    logic [31:0] exp_d;
    logic [31:0] a0;
    logic [31:0] b0;
    n     = vals.size();
    sat   = (1 << cw[k]) - 1;
    exp_c = (n > sat) ? sat : n;
    s     = 0.0;
    foreach (vals[i]) s = s + f2r(vals[i]);
    exp_d = (n == 1) ? vals[0] : r2f(s);
    a0    = add_a[k];
    b0    = add_b[k];
    for (int i = 0; i < n; i++) begin
      gap = int'($urandom_range(gap_max));
      repeat (gap) begin
        in_valid[k] = 1'b0;
        in_data[k]  = $urandom;
        in_last[k]  = 1'($urandom);
        step();
      end
      in_valid[k] = 1'b1;
      in_data[k]  = vals[i];
      in_last[k]  = (i == n - 1);
      checks++;
      if (in_ready[k] !== 1'b1) begin
        failures++;
        $display("FAIL %s in_ready_before_elem%0d: got %b expected 1", tag, i, in_ready[k]);
      end
      step();
      in_valid[k] = 1'b0;
      in_data[k]  = $urandom;
      in_last[k]  = 1'b0;
      checks++;
      if (busy[k] !== 1'b1) begin
        failures++;
        $display("FAIL %s busy_after_elem%0d: got %b expected 1", tag, i, busy[k]);
      end
      if (i < n - 1) begin
        w = 0;
        while (in_ready[k] !== 1'b1 && w < 50) begin
          step();
          w++;
        end
        exp_w = (i == 0) ? 0 : lat[k] + 1;
        checks++;
        if (w != exp_w) begin
          failures++;
          $display("FAIL %s ready_stall_elem%0d: got %0d cycles expected %0d", tag, i, w, exp_w);
        end
      end
    end
    w = 0;
    while (out_valid[k] !== 1'b1 && w < 50) begin
      step();
      w++;
    end
    exp_w = (n == 1) ? 0 : lat[k] + 1;
    checks++;
    if (w != exp_w) begin
      failures++;
      $display("FAIL %s out_valid_latency: got %0d cycles expected %0d", tag, w, exp_w);
    end
    bp = int'($urandom_range(bp_max));
    for (int j = 0; j < bp; j++) begin
      checks++;
      if (out_valid[k] !== 1'b1 || out_data[k] !== exp_d || out_count[k] !== 16'(exp_c) ||
          in_ready[k] !== 1'b0) begin
        failures++;
        $display("FAIL %s hold_cycle%0d: got v=%b d=%h c=%0d r=%b expected v=1 d=%h c=%0d r=0",
                 tag, j, out_valid[k], out_data[k], out_count[k], in_ready[k], exp_d, exp_c);
      end
      step();
    end
    out_ready[k] = 1'b1;
    checks++;
    if (out_data[k] !== exp_d) begin
      failures++;
      $display("FAIL %s out_data: got %h expected %h", tag, out_data[k], exp_d);
    end
    checks++;
    if (out_count[k] !== 16'(exp_c)) begin
      failures++;
      $display("FAIL %s out_count: got %0d expected %0d", tag, out_count[k], exp_c);
    end
    checks++;
    if (out_valid[k] !== 1'b1 || in_ready[k] !== 1'b0) begin
      failures++;
      $display("FAIL %s done_state: got v=%b r=%b expected v=1 r=0", tag, out_valid[k],
               in_ready[k]);
    end
    step();
    out_ready[k] = 1'b0;
    checks++;
    if (out_valid[k] !== 1'b0 || busy[k] !== 1'b0 || in_ready[k] !== 1'b1) begin
      failures++;
      $display("FAIL %s back_to_idle: got v=%b busy=%b r=%b expected v=0 busy=0 r=1", tag,
               out_valid[k], busy[k], in_ready[k]);
    end
    if (n == 1) begin
      checks++;
      if (add_a[k] !== a0 || add_b[k] !== b0) begin
        failures++;
        $display("FAIL %s adder_untouched: got a=%h b=%h expected a=%h b=%h", tag, add_a[k],
                 add_b[k], a0, b0);
      end
    end
  endtask

  task automatic check_zero(input int k, input string tag);
    checks++;
    if (out_valid[k] !== 1'b0 || out_data[k] !== 32'h0 || out_count[k] !== 16'h0 ||
        add_a[k] !== 32'h0 || add_b[k] !== 32'h0 || busy[k] !== 1'b0 || in_ready[k] !== 1'b1)
    begin
      failures++;
      $display("FAIL %s inst%0d: got v=%b d=%h c=%0d a=%h b=%h busy=%b r=%b expected zeros, r=1",
               tag, k, out_valid[k], out_data[k], out_count[k], add_a[k], add_b[k], busy[k],
               in_ready[k]);
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) check_zero(k, "reset_state");
  endtask

  task automatic test_basic_sum();
    logic [31:0] q[$];
    q.push_back(32'h3F800000);
    q.push_back(32'h40000000);
    q.push_back(32'h40400000);
    run_pkt(0, q, 0, 0, "basic_sum");
  endtask

  task automatic test_single();
    logic [31:0] q[$];
    q.push_back(32'hBFC00000);
    run_pkt(0, q, 0, 0, "single_elem");
  endtask

  task automatic test_out_backpressure();
    logic [31:0] q[$];
    q.push_back(32'h3F800000);
    q.push_back(32'h40000000);
    q.push_back(32'h40400000);
    run_pkt(0, q, 0, 5, "out_backpressure");
  endtask

  task automatic test_add_latency();
    logic [31:0] q[$];
    q.push_back(32'h40000000);
    q.push_back(32'h40000000);
    run_pkt(1, q, 0, 0, "add_lat2");
  endtask

  task automatic test_reset_mid();
    logic [31:0] q[$];
    in_valid[1] = 1'b1;
    in_data[1]  = 32'h3F800000;
    in_last[1]  = 1'b0;
    step();
    in_data[1]  = 32'h40000000;
    step();
    in_valid[1] = 1'b0;
    checks++;
    if (busy[1] !== 1'b1 || in_ready[1] !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid in_wait: got busy=%b r=%b expected busy=1 r=0", busy[1],
               in_ready[1]);
    end
    rst_n = 1'b0;
    #1;
    check_zero(1, "reset_mid_async");
    step();
    step();
    rst_n = 1'b1;
    step();
    check_zero(1, "reset_mid_released");
    q.push_back(32'h3F800000);
    run_pkt(1, q, 0, 1, "reset_mid_next");
  endtask

  task automatic test_saturate();
    logic [31:0] q[$];
    repeat (5) q.push_back(32'h3F800000);
    run_pkt(2, q, 0, 0, "count_saturate");
  endtask

  task automatic test_random();
    logic [31:0] q[$];
    int          len;
    for (int k = 0; k < 3; k++) begin
      for (int p = 0; p < 8; p++) begin
        q.delete();
        len = int'($urandom_range(8, 1));
        for (int i = 0; i < len; i++) q.push_back(rand_val());
        run_pkt(k, q, 2, 3, $sformatf("random_i%0d_p%0d", k, p));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] q[$];
    for (int p = 0; p < 4; p++) begin
      q.delete();
      for (int i = 0; i < p + 1; i++) q.push_back(rand_val());
      run_pkt(1, q, 0, 0, $sformatf("back_to_back_p%0d", p));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid[k]  = 1'b0;
      in_data[k]   = 32'h0;
      in_last[k]   = 1'b0;
      out_ready[k] = 1'b0;
    end
    #1;
    test_reset();
    step();
    step();
    rst_n = 1'b1;
    step();
    test_reset();
    test_basic_sum();
    test_single();
    test_out_backpressure();
    test_add_latency();
    test_reset_mid();
    test_saturate();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
